// File: rtl/axis_frame_sink_if.sv
// AXI4-Stream beat bundle for the frame sink. The upstream side uses master
// and the sink uses slave.
interface axis_frame_sink_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = ((DATA_WIDTH + 7) / 8),
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_sink.sv
// AXI4-Stream frame sink: measures each frame, classifies it as good or bad,
// and queues one status record per frame for control logic to pop.
module axis_frame_sink #(
    parameter int                    DATA_WIDTH           = 8,
    parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
    parameter int                    KEEP_WIDTH           = ((DATA_WIDTH + 7) / 8),
    parameter int                    USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
    parameter int                    LEN_WIDTH            = 16,
    parameter int                    MAX_LEN              = 1518,
    parameter int                    STAT_DEPTH           = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_frame_sink_if.slave     s_axis,
    output logic [LEN_WIDTH-1:0] m_stat_len,
    output logic                 m_stat_bad,
    output logic                 m_stat_oversize,
    output logic                 m_stat_valid,
    input  logic                 m_stat_ready,
    output logic [31:0]          cnt_good,
    output logic [31:0]          cnt_bad,
    output logic                 busy
);
    localparam int ADDR_W = $clog2(STAT_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int SUM_W  = LEN_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [31:0]      MAX_LEN_U = MAX_LEN;

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic [LEN_WIDTH-1:0] len;
        logic                 bad;
        logic                 oversize;
    } stat_t;

    state_t               state, state_next;
    stat_t                mem [STAT_DEPTH];
    stat_t                head, rec;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LEN_WIDTH-1:0] len_acc;
    logic                 sat;
    logic [SUM_W-1:0]     beat_bytes, sum;
    logic                 frame_sat, full, empty, beat_acc, push, pop;
    logic                 unused_sink;

    // tdata is never inspected; tkeep is dead when KEEP_ENABLE=0.
    assign unused_sink = ^{s_axis.tdata, s_axis.tkeep};

    always_comb begin
        beat_bytes = '0;
        if (KEEP_ENABLE) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                beat_bytes = beat_bytes + SUM_W'(s_axis.tkeep[i]);
            end
        end else begin
            beat_bytes = SUM_W'(1);
        end
    end

    // A carry out of the accumulator is the saturation event; once sat is set
    // len_acc sits at all-ones, so any non-empty beat keeps carrying out.
    always_comb begin
        sum          = {1'b0, len_acc} + beat_bytes;
        frame_sat    = sat | sum[LEN_WIDTH];
        rec.len      = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
        rec.bad      = ((s_axis.tuser & USER_BAD_FRAME_MASK) ==
                        (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
        rec.oversize = frame_sat | (32'(rec.len) > MAX_LEN_U);
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign s_axis.tready = rst & ~full;
    assign beat_acc      = s_axis.tvalid & s_axis.tready;
    assign push          = beat_acc & s_axis.tlast;
    assign pop           = m_stat_ready & ~empty;

    assign head            = mem[rd_ptr[ADDR_W-1:0]];
    assign m_stat_valid    = ~empty;
    assign m_stat_len      = empty ? '0 : head.len;
    assign m_stat_bad      = ~empty & head.bad;
    assign m_stat_oversize = ~empty & head.oversize;

    // NOTE: sequential state uses <= so every always_ff sees pre-edge values
    // regardless of the order the simulator evaluates the blocks.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: default first so no branch leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat_acc && !s_axis.tlast) state_next = ACTIVE;
            ACTIVE:  if (beat_acc &&  s_axis.tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ACTIVE);
    end

    // NOTE: record storage is not reset; the empty flag masks stale entries,
    // so clearing the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= rec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len_acc  <= '0;
            sat      <= 1'b0;
            cnt_good <= '0;
            cnt_bad  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (beat_acc) begin
                if (s_axis.tlast) begin
                    len_acc <= '0;
                    sat     <= 1'b0;
                    if (rec.bad | rec.oversize) cnt_bad  <= cnt_bad + 32'd1;
                    else                        cnt_good <= cnt_good + 32'd1;
                end else begin
                    len_acc <= rec.len;
                    sat     <= frame_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_sink.sv
// Bench for axis_frame_sink: a 64-bit keep-enabled instance and an 8-bit
// instance with an 8-bit length field, driven from tables and random traffic.
module tb_axis_frame_sink;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_frame_sink_if #(.DATA_WIDTH(64)) if_a ();
    axis_frame_sink_if #(.DATA_WIDTH(8))  if_b ();

    logic [15:0] len_a;
    logic [7:0]  len_b;
    logic        bad_a, ov_a, valid_a, pop_a, busy_a;
    logic        bad_b, ov_b, valid_b, pop_b, busy_b;
    logic [31:0] good_a, badc_a, good_b, badc_b;

    axis_frame_sink #(.DATA_WIDTH(64)) u_dut_a (
        .clk(clk), .rst(rst), .s_axis(if_a.slave),
        .m_stat_len(len_a), .m_stat_bad(bad_a), .m_stat_oversize(ov_a),
        .m_stat_valid(valid_a), .m_stat_ready(pop_a),
        .cnt_good(good_a), .cnt_bad(badc_a), .busy(busy_a)
    );

    axis_frame_sink #(.DATA_WIDTH(8), .LEN_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .s_axis(if_b.slave),
        .m_stat_len(len_b), .m_stat_bad(bad_b), .m_stat_oversize(ov_b),
        .m_stat_valid(valid_b), .m_stat_ready(pop_b),
        .cnt_good(good_b), .cnt_bad(badc_b), .busy(busy_b)
    );

    typedef struct packed {
        logic        tready;
        logic        valid;
        logic [31:0] len;
        logic        bad;
        logic        ov;
        logic [31:0] good;
        logic [31:0] badc;
        logic        busy;
    } obs_t;

    typedef struct {
        int         sel;
        int         nbeats;
        logic [7:0] keep_mid;
        logic [7:0] keep_last;
        logic       user;
        int         exp_len;
        logic       exp_bad;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        int   len;
        logic bad;
        logic ov;
    } rec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_good [2];
    int   exp_bad  [2];
    vec_t vecs [12];
    logic [7:0] bp_keep [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t observe(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.tready = if_a.tready; o.valid = valid_a; o.len = 32'(len_a);
            o.bad = bad_a; o.ov = ov_a; o.good = good_a; o.badc = badc_a; o.busy = busy_a;
        end else begin
            o.tready = if_b.tready; o.valid = valid_b; o.len = 32'(len_b);
            o.bad = bad_b; o.ov = ov_b; o.good = good_b; o.badc = badc_b; o.busy = busy_b;
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] keep,
                         input logic last, input logic user);
        if (sel == 0) begin
            if_a.tvalid = v; if_a.tkeep = keep; if_a.tlast = last;
            if_a.tuser = user; if_a.tdata = {$urandom, $urandom};
        end else begin
            if_b.tvalid = v; if_b.tkeep = 1'b1; if_b.tlast = last;
            if_b.tuser = user; if_b.tdata = 8'($urandom);
        end
    endtask

    task automatic set_pop(input int sel, input logic v);
        if (sel == 0) pop_a = v;
        else          pop_b = v;
    endtask

    task automatic pop_one(input int sel);
        set_pop(sel, 1'b1);
        tick();
        set_pop(sel, 1'b0);
    endtask

    // Waits a bounded number of cycles for tready, then spends one edge on the beat.
    task automatic send_beat(input int sel, input logic [7:0] keep, input logic last, input logic user);
        obs_t o;
        drive(sel, 1'b1, keep, last, user);
        o = observe(sel);
        for (int w = 0; w < 64 && o.tready !== 1'b1; w++) begin
            tick();
            o = observe(sel);
        end
        check("beat_tready", o.tready, 1);
        tick();
    endtask

    task automatic send_frame(input int sel, input int nbeats, input logic [7:0] keep_mid,
                              input logic [7:0] keep_last, input logic user, output logic busy_first);
        obs_t o;
        busy_first = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            send_beat(sel, (b == nbeats - 1) ? keep_last : keep_mid, b == nbeats - 1, user);
            if (b == 0) begin
                o = observe(sel);
                busy_first = o.busy;
            end
        end
        drive(sel, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_head(input int sel, input string tag, input int len,
                               input logic bad, input logic ov);
        obs_t o;
        o = observe(sel);
        check({tag, "_valid"}, o.valid, 1);
        check({tag, "_len"}, o.len, 64'(len));
        check({tag, "_bad"}, o.bad, bad);
        check({tag, "_oversize"}, o.ov, ov);
    endtask

    task automatic expect_counts(input int sel, input string tag);
        obs_t o;
        o = observe(sel);
        check({tag, "_cnt_good"}, o.good, 64'(exp_good[sel]));
        check({tag, "_cnt_bad"}, o.badc, 64'(exp_bad[sel]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t  o;
        string tag;
        logic  bf;
        rec_t  mq [$];
        rec_t  e;
        int    total;
        logic  in_frame;
        logic  v, l, u, r, acc, exp_rdy;
        logic [7:0] k;

        vecs[0]  = '{0,   8, 8'hFF, 8'h0F, 1'b0,   60, 1'b0, 1'b0};
        vecs[1]  = '{0,   1, 8'h00, 8'h01, 1'b1,    1, 1'b1, 1'b0};
        vecs[2]  = '{0, 190, 8'hFF, 8'h7F, 1'b0, 1519, 1'b0, 1'b1};
        vecs[3]  = '{0, 190, 8'hFF, 8'h3F, 1'b0, 1518, 1'b0, 1'b0};
        vecs[4]  = '{0,   2, 8'hFF, 8'h00, 1'b0,    8, 1'b0, 1'b0};
        vecs[5]  = '{0,   1, 8'h00, 8'h00, 1'b0,    0, 1'b0, 1'b0};
        vecs[6]  = '{0,   3, 8'h00, 8'h00, 1'b1,    0, 1'b1, 1'b0};
        vecs[7]  = '{0,   4, 8'hA5, 8'h81, 1'b0,   14, 1'b0, 1'b0};
        vecs[8]  = '{1, 300, 8'h01, 8'h01, 1'b0,  255, 1'b0, 1'b1};
        vecs[9]  = '{1, 255, 8'h01, 8'h01, 1'b0,  255, 1'b0, 1'b0};
        vecs[10] = '{1, 256, 8'h01, 8'h01, 1'b0,  255, 1'b0, 1'b1};
        vecs[11] = '{1,   2, 8'h01, 8'h01, 1'b1,    2, 1'b1, 1'b0};
        bp_keep  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
        exp_good = '{0, 0};
        exp_bad  = '{0, 0};

        // Reset state on both instances.
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        pop_a = 1'b0;
        pop_b = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            tag = $sformatf("reset%0d", s);
            check({tag, "_tready"}, o.tready, 0);
            check({tag, "_valid"}, o.valid, 0);
            check({tag, "_len"}, o.len, 0);
            check({tag, "_bad"}, o.bad, 0);
            check({tag, "_oversize"}, o.ov, 0);
            check({tag, "_busy"}, o.busy, 0);
            expect_counts(s, tag);
        end
        rst = 1'b1;
        tick();
        check("post_reset_tready_a", if_a.tready, 1);
        check("post_reset_tready_b", if_b.tready, 1);

        // Table-driven frames: one record each, inspected then popped.
        for (int i = 0; i < 12; i++) begin
            set_pop(vecs[i].sel, 1'b0);
            send_frame(vecs[i].sel, vecs[i].nbeats, vecs[i].keep_mid, vecs[i].keep_last,
                       vecs[i].user, bf);
            tag = $sformatf("vec%0d", i);
            check({tag, "_busy_first"}, bf, vecs[i].nbeats > 1);
            o = observe(vecs[i].sel);
            check({tag, "_busy_end"}, o.busy, 0);
            expect_head(vecs[i].sel, tag, vecs[i].exp_len, vecs[i].exp_bad, vecs[i].exp_ov);
            if (vecs[i].exp_bad || vecs[i].exp_ov) exp_bad[vecs[i].sel]++;
            else                                   exp_good[vecs[i].sel]++;
            expect_counts(vecs[i].sel, tag);
            pop_one(vecs[i].sel);
            o = observe(vecs[i].sel);
            check({tag, "_drained"}, o.valid, 0);
        end

        // Queue full backpressure: four records fill it, the fifth waits for a pop.
        for (int i = 0; i < 4; i++) send_beat(0, bp_keep[i], 1'b1, 1'b0);
        check("bp_full_tready", if_a.tready, 0);
        drive(0, 1'b1, bp_keep[4], 1'b1, 1'b0);
        tick();
        tick();
        check("bp_held_tready", if_a.tready, 0);
        expect_head(0, "bp_hold", 1, 1'b0, 1'b0);
        pop_one(0);
        check("bp_tready_after_pop", if_a.tready, 1);
        expect_head(0, "bp_after_pop", 2, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("bp_refull_tready", if_a.tready, 0);
        for (int i = 1; i < 5; i++) begin
            expect_head(0, $sformatf("bp_order%0d", i), i + 1, 1'b0, 1'b0);
            pop_one(0);
        end
        check("bp_empty", valid_a, 0);
        exp_good[0] += 5;
        expect_counts(0, "bp");

        // Push and pop in the same cycle at occupancy 2.
        send_beat(0, 8'h01, 1'b1, 1'b0);
        send_beat(0, 8'h03, 1'b1, 1'b0);
        drive(0, 1'b1, 8'h07, 1'b1, 1'b0);
        pop_a = 1'b1;
        check("pp_tready", if_a.tready, 1);
        tick();
        pop_a = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_head(0, "pp_head0", 2, 1'b0, 1'b0);
        pop_one(0);
        expect_head(0, "pp_head1", 3, 1'b0, 1'b0);
        pop_one(0);
        check("pp_empty", valid_a, 0);
        exp_good[0] += 3;
        expect_counts(0, "pp");

        // Reset in the middle of a frame discards it.
        for (int i = 0; i < 3; i++) send_beat(1, 8'h01, 1'b0, 1'b0);
        check("mid_busy", busy_b, 1);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        exp_good = '{0, 0};
        exp_bad  = '{0, 0};
        o = observe(1);
        check("mid_rst_tready", o.tready, 0);
        check("mid_rst_busy", o.busy, 0);
        check("mid_rst_valid", o.valid, 0);
        expect_counts(1, "mid_rst");
        rst = 1'b1;
        tick();
        check("mid_rst_release_tready", if_b.tready, 1);
        send_frame(1, 2, 8'h01, 8'h01, 1'b0, bf);
        expect_head(1, "mid_rst_frame", 2, 1'b0, 1'b0);
        exp_good[1]++;
        expect_counts(1, "mid_rst_frame");
        pop_one(1);
        check("mid_rst_single_record", valid_b, 0);

        // Random traffic on instance A against a frame-level model.
        total    = 0;
        in_frame = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            v = ($urandom_range(0, 3) != 0);
            k = 8'($urandom_range(0, 255));
            l = ($urandom_range(0, 3) == 0);
            u = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            drive(0, v, k, l, u);
            pop_a = r;
            exp_rdy = (mq.size() < 4);
            check("rnd_tready", if_a.tready, exp_rdy);
            if (mq.size() > 0) expect_head(0, "rnd_head", mq[0].len, mq[0].bad, mq[0].ov);
            else               check("rnd_empty", valid_a, 0);
            acc = v && exp_rdy;
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                total += $countones(k);
                if (l) begin
                    e.len = (total > 65535) ? 65535 : total;
                    e.ov  = (total > 1518);
                    e.bad = u;
                    mq.push_back(e);
                    if (e.bad || e.ov) exp_bad[0]++;
                    else               exp_good[0]++;
                    total    = 0;
                    in_frame = 1'b0;
                end else begin
                    in_frame = 1'b1;
                end
            end
            tick();
            expect_counts(0, "rnd");
            check("rnd_busy", busy_a, in_frame);
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        pop_a = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
